race_timer_scoreboard: RTL and testbench

Timing/scoreboard end of the drag-race game. Consumes the race state machine's event outputs (launch, finish, crash, save request) and produces the start countdown, the Go light, the elapsed race time in centiseconds, and the retained best time. Returns a one-cycle save acknowledge so the state machine can leave its SaveBest state. Sits between the race FSM and the seven-segment display driver.

---
 rtl/race_timer_scoreboard.sv | 209 ++++++++++++++++++++
 tb/tb_race_timer_scoreboard.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_timer_scoreboard.sv
// Race timer and best-time scoreboard for the drag-race game.
// Turns the race FSM's level events into a start countdown, a Go light, the
// elapsed race time in centiseconds and a retained best time. It also returns
// a one-cycle save acknowledge so the race FSM can leave its SaveBest state.
//
// Ports:
//   clock, reset          : system clock; synchronous active-high reset
//   new_game              : level, restarts the countdown while high
//   launch/finish/crash   : level events from the race FSM
//   save_req              : level, race FSM is in SaveBest
//   count_down_time [2:0] : seconds left in the countdown
//   go                    : start light
//   race_time      [13:0] : elapsed race time, centiseconds
//   best_time      [13:0] : best saved time, meaningful when best_valid=1
//   best_valid            : at least one time saved since reset
//   new_record            : last save replaced best_time
//   save_ack              : one-cycle acknowledge of save_req
//   false_start           : launch came before go
//   timeout               : race_time saturated at TIME_MAX
module race_timer_scoreboard #(
    parameter int unsigned TICK_DIV    = 500000,
    parameter int unsigned CS_PER_SEC  = 100,
    parameter int unsigned COUNT_START = 3,
    parameter int unsigned TIME_MAX    = 9999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        new_game,
    input  logic        launch,
    input  logic        finish,
    input  logic        crash,
    input  logic        save_req,
    output logic [2:0]  count_down_time,
    output logic        go,
    output logic [13:0] race_time,
    output logic [13:0] best_time,
    output logic        best_valid,
    output logic        new_record,
    output logic        save_ack,
    output logic        false_start,
    output logic        timeout
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (CS_PER_SEC > 1) ? $clog2(CS_PER_SEC) : 1;
    localparam int unsigned TW = 14;
    localparam int unsigned CW = 3;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SEC_LAST   = SW'(CS_PER_SEC - 1);
    localparam logic [TW-1:0] TIME_LIMIT = TW'(TIME_MAX);
    localparam logic [TW-1:0] TIME_PRE   = TW'(TIME_MAX - 1);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(COUNT_START);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COUNTDOWN = 3'd1;
    localparam logic [2:0] S_ARMED     = 3'd2;
    localparam logic [2:0] S_RUNNING   = 3'd3;
    localparam logic [2:0] S_FINISHED  = 3'd4;
    localparam logic [2:0] S_SAVED     = 3'd5;
    localparam logic [2:0] S_CRASHED   = 3'd6;

    logic [2:0]    state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [SW-1:0] sec, sec_nxt;
    logic          tick_c;

    logic [CW-1:0] cdt_nxt;
    logic          go_nxt;
    logic [TW-1:0] rt_nxt;
    logic [TW-1:0] bt_nxt;
    logic          bv_nxt;
    logic          nr_nxt;
    logic          ack_nxt;
    logic          fs_nxt;
    logic          to_nxt;

    // Centisecond strobe: last cycle of each prescaler period.
    assign tick_c = (presc == PRESC_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        presc_nxt = tick_c ? '0 : presc + PW'(1);
        sec_nxt   = sec;
        cdt_nxt   = count_down_time;
        go_nxt    = go;
        rt_nxt    = race_time;
        bt_nxt    = best_time;
        bv_nxt    = best_valid;
        nr_nxt    = new_record;
        ack_nxt   = 1'b0;
        fs_nxt    = false_start;
        to_nxt    = timeout;

        if (new_game) begin
            // Restart from any state; the best time survives.
            state_nxt = S_COUNTDOWN;
            presc_nxt = '0;
            sec_nxt   = '0;
            cdt_nxt   = COUNT_LOAD;
            go_nxt    = 1'b0;
            rt_nxt    = '0;
            fs_nxt    = 1'b0;
            to_nxt    = 1'b0;
            nr_nxt    = 1'b0;
        end else begin
            case (state)
                S_COUNTDOWN: begin
                    if (launch) begin
                        fs_nxt    = 1'b1;
                        state_nxt = S_CRASHED;
                    end else if (tick_c) begin
                        if (sec == SEC_LAST) begin
                            sec_nxt = '0;
                            cdt_nxt = count_down_time - CW'(1);
                            if (count_down_time == CW'(1)) begin
                                go_nxt    = 1'b1;
                                state_nxt = S_ARMED;
                            end
                        end else begin
                            sec_nxt = sec + SW'(1);
                        end
                    end
                end

                S_ARMED: begin
                    if (launch) begin
                        state_nxt = S_RUNNING;
                        presc_nxt = '0;
                    end
                end

                S_RUNNING: begin
                    // Finish wins over both crash and a coincident tick.
                    if (finish) begin
                        go_nxt    = 1'b0;
                        state_nxt = S_FINISHED;
                    end else begin
                        if (tick_c) begin
                            if (race_time == TIME_PRE) begin
                                rt_nxt    = TIME_LIMIT;
                                to_nxt    = 1'b1;
                                go_nxt    = 1'b0;
                                state_nxt = S_CRASHED;
                            end else begin
                                rt_nxt = race_time + TW'(1);
                            end
                        end
                        if (crash) begin
                            go_nxt    = 1'b0;
                            state_nxt = S_CRASHED;
                        end
                    end
                end

                S_FINISHED: begin
                    if (save_req) begin
                        state_nxt = S_SAVED;
                        ack_nxt   = 1'b1;
                        // A tie does not count as a record.
                        if (!best_valid || (race_time < best_time)) begin
                            bt_nxt = race_time;
                            bv_nxt = 1'b1;
                            nr_nxt = 1'b1;
                        end else begin
                            nr_nxt = 1'b0;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            presc           <= '0;
            sec             <= '0;
            count_down_time <= '0;
            go              <= 1'b0;
            race_time       <= '0;
            best_time       <= '0;
            best_valid      <= 1'b0;
            new_record      <= 1'b0;
            save_ack        <= 1'b0;
            false_start     <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            state           <= state_nxt;
            presc           <= presc_nxt;
            sec             <= sec_nxt;
            count_down_time <= cdt_nxt;
            go              <= go_nxt;
            race_time       <= rt_nxt;
            best_time       <= bt_nxt;
            best_valid      <= bv_nxt;
            new_record      <= nr_nxt;
            save_ack        <= ack_nxt;
            false_start     <= fs_nxt;
            timeout         <= to_nxt;
        end
    end

endmodule

// File: tb/tb_race_timer_scoreboard.sv
// Scoreboard bench for race_timer_scoreboard: the driver feeds inputs each cycle
// and queues the expected outputs from an elapsed-time reference model; a
// negedge monitor pops each expectation and compares it with the DUT.
module tb_race_timer_scoreboard;

    localparam int unsigned TD  = 2;
    localparam int unsigned CPS = 100;
    localparam int unsigned CS  = 3;
    localparam int unsigned TM  = 200;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        new_game  = 1'b0;
    logic        launch    = 1'b0;
    logic        finish    = 1'b0;
    logic        crash     = 1'b0;
    logic        save_req  = 1'b0;
    logic [2:0]  count_down_time;
    logic        go;
    logic [13:0] race_time;
    logic [13:0] best_time;
    logic        best_valid;
    logic        new_record;
    logic        save_ack;
    logic        false_start;
    logic        timeout;

    always #5 clock = ~clock;

    race_timer_scoreboard #(
        .TICK_DIV   (TD),
        .CS_PER_SEC (CPS),
        .COUNT_START(CS),
        .TIME_MAX   (TM)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .new_game       (new_game),
        .launch         (launch),
        .finish         (finish),
        .crash          (crash),
        .save_req       (save_req),
        .count_down_time(count_down_time),
        .go             (go),
        .race_time      (race_time),
        .best_time      (best_time),
        .best_valid     (best_valid),
        .new_record     (new_record),
        .save_ack       (save_ack),
        .false_start    (false_start),
        .timeout        (timeout)
    );

    typedef struct packed {
        logic [2:0]  cdt;
        logic        go;
        logic [13:0] rt;
        logic [13:0] bt;
        logic        bv;
        logic        nr;
        logic        ack;
        logic        fs;
        logic        to;
    } obs_t;

    typedef enum int {P_IDLE, P_CD, P_ARMED, P_RUN, P_FIN, P_SAVED, P_CRASH} phase_t;

    obs_t   exp_q[$];
    obs_t   m;
    obs_t   got;
    obs_t   want;
    phase_t ph = P_IDLE;
    int     cd_n = 0;
    int     run_n = 0;
    int     vectors = 0;
    int     miscompares = 0;

    // Reference model: outputs derived from elapsed cycle counts.
    // After n clock edges since a prescaler clear, n/TD ticks have taken effect.
    function void model(input logic r, input logic ng, input logic la,
                        input logic fi, input logic cr, input logic sr);
        int t;
        m.ack = 1'b0;
        if (r) begin
            m = '0;
            ph = P_IDLE;
            cd_n = 0;
            run_n = 0;
        end else if (ng) begin
            ph = P_CD;
            cd_n = 0;
            m.cdt = 3'(CS);
            m.go = 1'b0;
            m.rt = '0;
            m.fs = 1'b0;
            m.to = 1'b0;
            m.nr = 1'b0;
        end else begin
            case (ph)
                P_CD: begin
                    if (la) begin
                        m.fs = 1'b1;
                        ph = P_CRASH;
                    end else begin
                        cd_n++;
                        t = int'(CS) - (cd_n / int'(TD)) / int'(CPS);
                        m.cdt = 3'(t);
                        if (t == 0) begin
                            m.go = 1'b1;
                            ph = P_ARMED;
                        end
                    end
                end
                P_ARMED: begin
                    if (la) begin
                        ph = P_RUN;
                        run_n = 0;
                    end
                end
                P_RUN: begin
                    run_n++;
                    if (fi) begin
                        m.go = 1'b0;
                        ph = P_FIN;
                    end else begin
                        t = run_n / int'(TD);
                        if (t > int'(TM)) t = int'(TM);
                        m.rt = 14'(t);
                        if (t == int'(TM)) begin
                            m.to = 1'b1;
                            m.go = 1'b0;
                            ph = P_CRASH;
                        end else if (cr) begin
                            m.go = 1'b0;
                            ph = P_CRASH;
                        end
                    end
                end
                P_FIN: begin
                    if (sr) begin
                        ph = P_SAVED;
                        m.ack = 1'b1;
                        if (!m.bv || (m.rt < m.bt)) begin
                            m.bt = m.rt;
                            m.bv = 1'b1;
                            m.nr = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    endfunction

    // One clock: drive inputs, queue the expected post-edge outputs.
    task automatic cyc(input logic r, input logic ng, input logic la,
                       input logic fi, input logic cr, input logic sr);
        reset = r;
        new_game = ng;
        launch = la;
        finish = fi;
        crash = cr;
        save_req = sr;
        model(r, ng, la, fi, cr, sr);
        @(posedge clock);
        exp_q.push_back(m);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic save_hold(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_armed();
        int g;
        g = 0;
        while (ph != P_ARMED && g < 2000) begin
            idle(1);
            g++;
        end
        if (ph != P_ARMED) begin
            miscompares++;
            $display("FAIL wait_armed: model phase %0d after %0d cycles, required ARMED", ph, g);
        end
    endtask

    // ending: 0 finish, 1 crash, 2 finish+crash, 3 nothing, 4 new game abort
    task automatic race(input int delay, input int len, input int ending, input int saves);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_armed();
        idle(delay);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(len - 1);
        case (ending)
            0: cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            1: cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            2: cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            4: cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            default: idle(1);
        endcase
        idle(2);
        save_hold(saves);
        idle(2);
    endtask

    // Monitor: every cycle the DUT presents a result that must match the queue head.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = {count_down_time, go, race_time, best_time, best_valid,
                   new_record, save_ack, false_start, timeout};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL outputs vec %0d: got cdt=%0d go=%0b rt=%0d bt=%0d bv=%0b nr=%0b ack=%0b fs=%0b to=%0b; want cdt=%0d go=%0b rt=%0d bt=%0d bv=%0b nr=%0b ack=%0b fs=%0b to=%0b",
                         vectors, got.cdt, got.go, got.rt, got.bt, got.bv, got.nr, got.ack, got.fs, got.to,
                         want.cdt, want.go, want.rt, want.bt, want.bv, want.nr, want.ack, want.fs, want.to);
            end
        end
    end

    initial begin
        // Reset state.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // First finished run sets the record; save_req held produces one ack.
        race(5, 250, 0, 3);
        // Slower run: no record.
        race(5, 262, 0, 2);
        // Exact tie: no record.
        race(5, 250, 0, 2);

        // False start while two seconds remain; saves are ignored.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(250);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(700);
        save_hold(3);
        idle(2);

        // Saturation at TIME_MAX with no finish.
        race(3, 2 * int'(TM) + 20, 3, 2);
        // Finish and crash together: finish wins, faster time is a record.
        race(2, 101, 2, 2);
        // Plain crash mid-run.
        race(0, 77, 1, 2);

        // Reset in the middle of a run clears the best time too.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_armed();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(30);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // New game held for ten cycles: counting starts after release.
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_armed();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(140);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        save_hold(2);
        idle(2);

        // Randomized races.
        for (int k = 0; k < 15; k++) begin
            int d, l, e, s;
            d = int'($urandom_range(0, 8));
            l = int'($urandom_range(1, 450));
            e = int'($urandom_range(0, 4));
            s = int'($urandom_range(0, 3));
            race(d, l, e, s);
        end

        idle(2);
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
